seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-004 The block SHALL have port start, input, 1: request a division; sampled on rising edges only while in IDLE.
REQ-005 The block SHALL have port abort, input, 1: synchronous cancel of the current operation; return to IDLE with no done.
REQ-006 The block SHALL have port dividend, input, WIDTH: signed two's-complement dividend; sampled only on the edge that accepts start.
REQ-007 The block SHALL have port divisor, input, WIDTH: signed two's-complement divisor; sampled only on the edge that accepts start.
REQ-008 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1: single-cycle completion pulse.
REQ-010 The block SHALL have port div_zero, output, 1: single-cycle pulse, coincident with done, flagging divisor==0.
REQ-011 The block SHALL have port hi, output, WIDTH: remainder of the last successful operation.
REQ-012 The block SHALL have port lo, output, WIDTH: quotient of the last successful operation.

Function
REQ-013 The state machine SHALL have states IDLE, RUN, FIX and DONE, all held in registers; busy, done and div_zero SHALL be registered outputs.
REQ-014 In IDLE, with start=1 at edge N and divisor!=0, the block SHALL latch the operand magnitudes and signs, clear the partial remainder and the iteration counter, and enter RUN.
REQ-015 In IDLE, with start=1 at edge N and divisor==0, the block SHALL enter DONE with done=1 and div_zero=1 from edge N+1; hi and lo SHALL stay unchanged.
REQ-016 In RUN, each edge SHALL perform one restoring-division step on magnitudes: shift {rem,quo} left by 1; if rem>=|divisor|, subtract |divisor| and set the quotient LSB.
REQ-017 The block SHALL leave RUN for FIX after exactly WIDTH steps, i.e. the counter runs 0..WIDTH-1 with no wrap.
REQ-018 At the FIX edge, the block SHALL load lo = quotient, negated if the operand signs differ, and hi = remainder, negated if the dividend is negative; both truncate toward zero, as MIPS DIV does. It SHALL set done=1 and enter DONE.
REQ-019 Latency SHALL be fixed: start accepted at edge N gives done and valid hi/lo from edge N+WIDTH+1 (N+33 for WIDTH=32).
REQ-020 DONE SHALL last exactly one cycle; the block SHALL then return to IDLE with done=0 and div_zero=0.
REQ-021 A start arriving in DONE SHALL be ignored.
REQ-022 hi and lo SHALL hold their values until the next FIX edge; they SHALL never show intermediate values.
REQ-023 start SHALL be ignored while busy=1; an operation in progress SHALL NOT restart or re-sample its operands.
REQ-024 abort=1 in RUN or FIX SHALL return the block to IDLE on that edge, with hi/lo unchanged and no done pulse; abort has priority over the FIX update.
REQ-025 abort=1 in IDLE SHALL have no effect; when abort and start are high on the same edge in IDLE, abort wins and the block stays in IDLE.
REQ-026 The overflow case dividend=-2^(WIDTH-1), divisor=-1 SHALL produce lo=-2^(WIDTH-1) (0x80000000) and hi=0, with no flag raised.
REQ-027 A dividend of 0 SHALL produce lo=0 and hi=0; |dividend|<|divisor| SHALL produce lo=0 and hi=dividend.

Reset
REQ-028 While reset=0, the block SHALL hold state IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0 and all internal operand registers at 0.
REQ-029 reset asserted mid-RUN SHALL abandon the operation immediately; after release, no done SHALL appear until a new start is accepted.

Verification
REQ-030 The bench SHALL apply 100/7 with start at edge N and require done=1, lo=14 and hi=2 exactly at edge N+33, and done=0 at N+34.
REQ-031 The bench SHALL apply -7/2 (0xFFFFFFF9/0x00000002) and require lo=0xFFFFFFFD and hi=0xFFFFFFFF; it SHALL also apply 7/-2 and require lo=0xFFFFFFFD and hi=0x00000001.
REQ-032 The bench SHALL apply 5/0 after a prior 100/7 and require done=1 and div_zero=1 at N+1 for one cycle, with hi=2 and lo=14 unchanged.
REQ-033 The bench SHALL apply 0x80000000/0xFFFFFFFF and require lo=0x80000000, hi=0 and div_zero=0.
REQ-034 The bench SHALL pulse start with 9/3 at N+5 during a 100/7 operation and require the 100/7 result at N+33 with no second done; it SHALL then assert abort at N+10 on a fresh operation and require no done and hi/lo held.
REQ-035 The bench SHALL drive reset=0 asynchronously at N+12 of a 100/7 operation and require busy=0, hi=0 and lo=0 immediately, with no done after release.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per clock, with results truncated toward zero as MIPS DIV does.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divz_q, divz_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] quo_sh;

  // The magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude, so no extra bit is needed.
  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    rem_sh  = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    quo_sh  = {quo_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    divz_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !abort) begin
          busy_d = 1'b1;
          zero_d = (divisor == '0);
          // A zero divisor skips the iterations and reports through FIX.
          if (divisor == '0) begin
            state_d = FIX;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = dvd_mag;
            dvsr_d  = dvs_mag;
            qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d  = dividend[WIDTH-1];
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          if (rem_sh >= dvsr_q) begin
            rem_d = rem_sh - dvsr_q;
            quo_d = quo_sh | {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            rem_d = rem_sh;
            quo_d = quo_sh;
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIX: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          if (zero_q) begin
            divz_d = 1'b1;
          end else begin
            lo_d = qneg_q ? (~quo_q + 1'b1) : quo_q;
            hi_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = divz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients, remainders and
// edge-exact timing of done for a 32-bit instance.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int testsRun = 0;
  int testsFailed = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents operands with start for exactly one edge; returns just after edge N.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) n++;
    end
  endtask

  int ndone;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    dividend = '0;
    divisor = '0;
    #12;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_divz", {31'd0, div_zero}, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 100/7: done exactly at N+33 and gone at N+34
    applyStimulus(32'd100, 32'd7);
    checkOutput("run_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 32; i++) tick();
    checkOutput("n32_done", {31'd0, done}, 32'd0);
    checkOutput("n32_lo_held", lo, 32'd0);
    tick();
    checkOutput("n33_done", {31'd0, done}, 32'd1);
    checkOutput("n33_lo", lo, 32'd14);
    checkOutput("n33_hi", hi, 32'd2);
    checkOutput("n33_divz", {31'd0, div_zero}, 32'd0);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    checkOutput("n34_done", {31'd0, done}, 32'd0);
    checkOutput("n34_busy_start_in_done_ignored", {31'd0, busy}, 32'd0);
    checkOutput("n34_lo", lo, 32'd14);

    applyStimulus(32'hFFFF_FFF9, 32'd2);
    for (int i = 1; i <= 33; i++) tick();
    checkOutput("m7d2_done", {31'd0, done}, 32'd1);
    checkOutput("m7d2_lo", lo, 32'hFFFF_FFFD);
    checkOutput("m7d2_hi", hi, 32'hFFFF_FFFF);
    tick();

    applyStimulus(32'd7, 32'hFFFF_FFFE);
    for (int i = 1; i <= 33; i++) tick();
    checkOutput("7dm2_lo", lo, 32'hFFFF_FFFD);
    checkOutput("7dm2_hi", hi, 32'd1);
    tick();

    // Divide by zero after a 100/7 result is in place
    applyStimulus(32'd100, 32'd7);
    for (int i = 1; i <= 34; i++) tick();
    applyStimulus(32'd5, 32'd0);
    checkOutput("dz_n0_done", {31'd0, done}, 32'd0);
    tick();
    checkOutput("dz_done", {31'd0, done}, 32'd1);
    checkOutput("dz_divz", {31'd0, div_zero}, 32'd1);
    checkOutput("dz_hi", hi, 32'd2);
    checkOutput("dz_lo", lo, 32'd14);
    tick();
    checkOutput("dz_done_off", {31'd0, done}, 32'd0);
    checkOutput("dz_divz_off", {31'd0, div_zero}, 32'd0);

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 1; i <= 33; i++) tick();
    checkOutput("ovf_done", {31'd0, done}, 32'd1);
    checkOutput("ovf_lo", lo, 32'h8000_0000);
    checkOutput("ovf_hi", hi, 32'd0);
    checkOutput("ovf_divz", {31'd0, div_zero}, 32'd0);
    tick();

    applyStimulus(32'd0, 32'd5);
    for (int i = 1; i <= 33; i++) tick();
    checkOutput("zero_lo", lo, 32'd0);
    checkOutput("zero_hi", hi, 32'd0);
    tick();
    applyStimulus(32'd3, 32'hFFFF_FFF9);
    for (int i = 1; i <= 33; i++) tick();
    checkOutput("small_lo", lo, 32'd0);
    checkOutput("small_hi", hi, 32'd3);
    tick();
    applyStimulus(32'hFFFF_FFFD, 32'd7);
    for (int i = 1; i <= 33; i++) tick();
    checkOutput("smallneg_lo", lo, 32'd0);
    checkOutput("smallneg_hi", hi, 32'hFFFF_FFFD);
    tick();

    // A start at N+5 must not disturb the running 100/7
    applyStimulus(32'd100, 32'd7);
    for (int i = 1; i <= 4; i++) tick();
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int i = 6; i <= 33; i++) tick();
    checkOutput("busy_start_done", {31'd0, done}, 32'd1);
    checkOutput("busy_start_lo", lo, 32'd14);
    checkOutput("busy_start_hi", hi, 32'd2);
    countDones(40, ndone);
    checkOutput("busy_start_no_second_done", ndone, 32'd0);

    // Abort at N+10 of a 9/3 operation
    applyStimulus(32'd9, 32'd3);
    for (int i = 1; i <= 9; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    countDones(40, ndone);
    checkOutput("abort_no_done", ndone, 32'd0);
    checkOutput("abort_hi", hi, 32'd2);
    checkOutput("abort_lo", lo, 32'd14);

    abort = 1'b1;
    applyStimulus(32'd9, 32'd3);
    abort = 1'b0;
    checkOutput("abort_start_idle_busy", {31'd0, busy}, 32'd0);
    countDones(40, ndone);
    checkOutput("abort_start_idle_no_done", ndone, 32'd0);

    // Asynchronous reset at N+12 of 100/7
    applyStimulus(32'd100, 32'd7);
    for (int i = 1; i <= 12; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_hi", hi, 32'd0);
    checkOutput("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    countDones(40, ndone);
    checkOutput("arst_no_done", ndone, 32'd0);
    checkOutput("arst_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
